// File: rtl/amba_axi4_stream_seda_pkg.sv
// Shared definitions for the AXI4-Stream packet source: integration
// defaults for the stream widths, the source state encoding and the
// seed of the optional stall LFSR.
package amba_axi4_stream_seda_pkg;

   localparam int AXI4_STREAM_DATA_WIDTH_BYTES = 4;
   localparam int AXI4_STREAM_ID_WIDTH         = 4;
   localparam int AXI4_STREAM_DEST_WIDTH       = 4;
   localparam int AXI4_STREAM_USER_WIDTH       = 1;

   localparam logic [15:0] PKT_SRC_LFSR_SEED = 16'hACE1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } pkt_src_state_e;

endpackage

// File: rtl/amba_axi4_stream_pkt_src_lfsr.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1 (maximal length).
// Steps every cycle; used to insert random single-cycle TVALID gaps.
module amba_axi4_stream_pkt_src_lfsr
   import amba_axi4_stream_seda_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Right-shifting form: taps 0,2,3,5 feed back into bit 15.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   // Free-running register, reloaded with the seed on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) lfsr_q <= PKT_SRC_LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/amba_axi4_stream_pkt_src.sv
// Command-driven AXI4-Stream packet source. Each accepted command with a
// non-zero length becomes one packet whose byte k is (seed+k) mod 256.
// Handshake: a beat transfers on the rising edge where TVALID && TREADY;
// once TVALID is high every stream output holds until that edge, and a
// command is taken on the edge where cmd_valid && cmd_ready.
// Optional macro AXI4S_PKT_SRC_STALL_EN inserts LFSR-driven one-cycle
// TVALID gaps after non-last beats.
module amba_axi4_stream_pkt_src
   import amba_axi4_stream_seda_pkg::*;
#(
   parameter int DATA_BYTES = AXI4_STREAM_DATA_WIDTH_BYTES,
   parameter int ID_WIDTH   = AXI4_STREAM_ID_WIDTH,
   parameter int DEST_WIDTH = AXI4_STREAM_DEST_WIDTH,
   parameter int USER_WIDTH = AXI4_STREAM_USER_WIDTH,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic [7:0]              cmd_seed,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic [DEST_WIDTH-1:0]   cmd_dest,
   output logic [DATA_BYTES*8-1:0] TDATA,
   output logic [DATA_BYTES-1:0]   TSTRB,
   output logic [DATA_BYTES-1:0]   TKEEP,
   output logic                    TLAST,
   output logic [ID_WIDTH-1:0]     TID,
   output logic [DEST_WIDTH-1:0]   TDEST,
   output logic [USER_WIDTH-1:0]   TUSER,
   output logic                    TVALID,
   input  logic                    TREADY,
   output logic                    busy,
   output logic [15:0]             pkt_count
);

   localparam int DW = DATA_BYTES * 8;
   localparam int CW = LEN_WIDTH + 1;

   pkt_src_state_e          state_q;
   logic [CW-1:0]           beats_left_q;   // beats still to present after the current one
   logic [7:0]              base_q;         // byte value of lane 0 in the next beat
   logic [DATA_BYTES-1:0]   last_keep_q;
   logic                    stall_q;
   logic [DW-1:0]           tdata_q;
   logic [DATA_BYTES-1:0]   tkeep_q;
   logic                    tlast_q;
   logic [ID_WIDTH-1:0]     tid_q;
   logic [DEST_WIDTH-1:0]   tdest_q;
   logic [USER_WIDTH-1:0]   tuser_q;
   logic                    tvalid_q;
   logic [15:0]             pkt_count_q;

   logic [CW-1:0]           len_ext;
   logic [CW-1:0]           acc_nbeats;
   logic [CW-1:0]           acc_rem;
   logic [DATA_BYTES-1:0]   acc_last_keep;
   logic [DATA_BYTES-1:0]   acc_first_keep;
   logic                    nxt_last;
   logic [DATA_BYTES-1:0]   nxt_keep;
   logic                    hs;
   logic                    stall_req;

   // Lanes with keep set carry base+lane, the rest are zero.
   function automatic logic [DW-1:0] beat_data(input logic [7:0] base,
                                               input logic [DATA_BYTES-1:0] keep);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         d[8*i +: 8] = keep[i] ? (base + 8'(i)) : 8'h00;
      end
      return d;
   endfunction

`ifdef AXI4S_PKT_SRC_STALL_EN
   logic [15:0] lfsr;

   amba_axi4_stream_pkt_src_lfsr u_lfsr (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .lfsr_o (lfsr)
   );

   assign stall_req = lfsr[0];
`else
   assign stall_req = 1'b0;
`endif

   // Command decode (beat count and last-beat lane mask) and next-beat shape.
   always_comb begin
      len_ext    = {1'b0, cmd_len};
      acc_nbeats = (len_ext + CW'(DATA_BYTES - 1)) / CW'(DATA_BYTES);
      acc_rem    = len_ext % CW'(DATA_BYTES);
      acc_last_keep = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         acc_last_keep[i] = (acc_rem == '0) || (CW'(i) < acc_rem);
      end
      acc_first_keep = (acc_nbeats == CW'(1)) ? acc_last_keep : '1;
      nxt_last = (beats_left_q == CW'(1));
      nxt_keep = nxt_last ? last_keep_q : '1;
      hs       = tvalid_q && TREADY;
   end

   // Source FSM with all stream outputs registered.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= IDLE;
         beats_left_q <= '0;
         base_q       <= '0;
         last_keep_q  <= '0;
         stall_q      <= 1'b0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tlast_q      <= 1'b0;
         tid_q        <= '0;
         tdest_q      <= '0;
         tuser_q      <= '0;
         tvalid_q     <= 1'b0;
         pkt_count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               stall_q <= 1'b0;
               // Zero-length commands are accepted and simply dropped.
               if (cmd_valid && (cmd_len != '0)) begin
                  state_q      <= SEND;
                  tvalid_q     <= 1'b1;
                  tuser_q      <= USER_WIDTH'(1);
                  tid_q        <= cmd_id;
                  tdest_q      <= cmd_dest;
                  tkeep_q      <= acc_first_keep;
                  tdata_q      <= beat_data(cmd_seed, acc_first_keep);
                  tlast_q      <= (acc_nbeats == CW'(1));
                  beats_left_q <= acc_nbeats - CW'(1);
                  base_q       <= cmd_seed + 8'(DATA_BYTES);
                  last_keep_q  <= acc_last_keep;
               end
            end
            SEND: begin
               if (stall_q) begin
                  // Gap cycle over: present the beat already loaded.
                  tvalid_q <= 1'b1;
                  stall_q  <= 1'b0;
               end else if (hs) begin
                  if (tlast_q) begin
                     state_q     <= IDLE;
                     tvalid_q    <= 1'b0;
                     tlast_q     <= 1'b0;
                     tuser_q     <= '0;
                     tdata_q     <= '0;
                     tkeep_q     <= '0;
                     pkt_count_q <= pkt_count_q + 16'd1;
                  end else begin
                     tdata_q      <= beat_data(base_q, nxt_keep);
                     tkeep_q      <= nxt_keep;
                     tlast_q      <= nxt_last;
                     tuser_q      <= '0;
                     beats_left_q <= beats_left_q - CW'(1);
                     base_q       <= base_q + 8'(DATA_BYTES);
                     tvalid_q     <= !stall_req;
                     stall_q      <= stall_req;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == SEND);
   assign TDATA     = tdata_q;
   assign TKEEP     = tkeep_q;
   assign TSTRB     = tkeep_q;
   assign TLAST     = tlast_q;
   assign TID       = tid_q;
   assign TDEST     = tdest_q;
   assign TUSER     = tuser_q;
   assign TVALID    = tvalid_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_amba_axi4_stream_pkt_src.sv
// Bench for amba_axi4_stream_pkt_src: directed vector table, hand-written
// stall/zero-length/reset sequences and random commands with random TREADY,
// all beats scored against a byte-level packet model.
module tb_amba_axi4_stream_pkt_src;

   localparam int BW = 46;  // {id, dest, user, last, keep, data}

   logic        ACLK;
   logic        ARESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_len;
   logic [7:0]  cmd_seed;
   logic [3:0]  cmd_id;
   logic [3:0]  cmd_dest;
   logic [31:0] TDATA;
   logic [3:0]  TSTRB;
   logic [3:0]  TKEEP;
   logic        TLAST;
   logic [3:0]  TID;
   logic [3:0]  TDEST;
   logic [0:0]  TUSER;
   logic        TVALID;
   logic        TREADY;
   logic        busy;
   logic [15:0] pkt_count;

   amba_axi4_stream_pkt_src dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .cmd_seed  (cmd_seed),
      .cmd_id    (cmd_id),
      .cmd_dest  (cmd_dest),
      .TDATA     (TDATA),
      .TSTRB     (TSTRB),
      .TKEEP     (TKEEP),
      .TLAST     (TLAST),
      .TID       (TID),
      .TDEST     (TDEST),
      .TUSER     (TUSER),
      .TVALID    (TVALID),
      .TREADY    (TREADY),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   // ---------------- clock ----------------
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // ---------------- bench state ----------------
   int unsigned checks;
   int unsigned errors;
   logic [BW-1:0] exp_q[$];
   logic [15:0]   exp_pkts;
   bit            rand_ready;
   int            obs_beats;
   logic [BW-1:0] obs_first;
   logic [BW-1:0] obs_last;

   typedef struct {
      logic [15:0] len;
      logic [7:0]  seed;
      logic [3:0]  id;
      logic [3:0]  dest;
      int          nbeats;
      logic [31:0] first_data;
      logic [3:0]  first_keep;
      logic [31:0] last_data;
      logic [3:0]  last_keep;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [BW-1:0] cur_beat();
      return {TID, TDEST, TUSER, TLAST, TKEEP, TDATA};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Packet model: byte k = seed+k, packed DATA_BYTES per beat, lane 0 low.
   task automatic push_pkt(input int len, input logic [7:0] seed,
                           input logic [3:0] id, input logic [3:0] dest);
      int nb;
      logic [31:0] d;
      logic [3:0]  k;
      if (len == 0) return;
      nb = (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         d = '0;
         k = '0;
         for (int i = 0; i < 4; i++) begin
            if (b * 4 + i < len) begin
               k[i] = 1'b1;
               d[8*i +: 8] = seed + 8'(b * 4 + i);
            end
         end
         exp_q.push_back({id, dest, 1'(b == 0), 1'(b == nb - 1), k, d});
      end
      exp_pkts++;
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge ACLK);
      #1;
      if (rand_ready) TREADY = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_cmd(input int len, input logic [7:0] seed,
                           input logic [3:0] id, input logic [3:0] dest);
      int n;
      n = 0;
      while (!cmd_ready && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) chk("cmd_ready_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b1;
      cmd_len   = 16'(len);
      cmd_seed  = seed;
      cmd_id    = id;
      cmd_dest  = dest;
      push_pkt(len, seed, id, dest);
      step();
      cmd_valid = 1'b0;
      cmd_len   = 16'($urandom_range(0, 65535));
      cmd_seed  = 8'($urandom_range(0, 255));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   // ---------------- scoreboard / protocol monitor ----------------
   task automatic monitor();
      logic          prev_valid;
      logic          prev_ready;
      logic [BW-1:0] prev_beat;
      logic [BW-1:0] cur;
      logic [BW-1:0] exp;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            prev_valid = 1'b0;
            continue;
         end
         cur = cur_beat();
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 64'(TVALID), 64'd1);
            chk("hold_beat", 64'(cur), 64'(prev_beat));
         end
         if (TVALID && TREADY) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(cur), 64'd0);
            end else begin
               exp = exp_q.pop_front();
               chk("beat", 64'(cur), 64'(exp));
               chk("strb", 64'(TSTRB), 64'(exp[35:32]));
            end
            obs_beats++;
            if (obs_beats == 1) obs_first = cur;
            obs_last = cur;
         end
         prev_valid = TVALID;
         prev_ready = TREADY;
         prev_beat  = cur;
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int len;
      logic [BW-1:0] held;

      checks = 0;
      errors = 0;
      exp_pkts = '0;
      rand_ready = 1'b0;
      obs_beats = 0;
      obs_first = '0;
      obs_last = '0;
      ARESET = 1'b1;
      cmd_valid = 1'b0;
      cmd_len = '0;
      cmd_seed = '0;
      cmd_id = '0;
      cmd_dest = '0;
      TREADY = 1'b0;

      vecs[0] = '{16'd6,  8'h10, 4'd3, 4'd5, 2, 32'h13121110, 4'hF, 32'h00001514, 4'h3};
      vecs[1] = '{16'd4,  8'hFE, 4'd1, 4'd2, 1, 32'h0100FFFE, 4'hF, 32'h0100FFFE, 4'hF};
      vecs[2] = '{16'd1,  8'hAA, 4'd0, 4'd0, 1, 32'h000000AA, 4'h1, 32'h000000AA, 4'h1};
      vecs[3] = '{16'd9,  8'h00, 4'd7, 4'd9, 3, 32'h03020100, 4'hF, 32'h00000008, 4'h1};
      vecs[4] = '{16'd8,  8'hFC, 4'd15, 4'd1, 2, 32'hFFFEFDFC, 4'hF, 32'h03020100, 4'hF};
      vecs[5] = '{16'd7,  8'h20, 4'd4, 4'd12, 2, 32'h23222120, 4'hF, 32'h00262524, 4'h7};

      fork
         monitor();
      join_none

      // Reset; a command presented during reset must be ignored.
      step();
      cmd_valid = 1'b1;
      cmd_len = 16'd5;
      step();
      step();
      chk("rst_tvalid", 64'(TVALID), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_outputs", 64'(cur_beat()), 64'd0);
      cmd_valid = 1'b0;
      ARESET = 1'b0;
      step();
      chk("post_rst_tvalid", 64'(TVALID), 64'd0);

      // Directed vector table, TREADY held high.
      TREADY = 1'b1;
      foreach (vecs[v]) begin
         obs_beats = 0;
         send_cmd(int'(vecs[v].len), vecs[v].seed, vecs[v].id, vecs[v].dest);
         chk("vec_busy", 64'(busy), 64'd1);
         drain();
         chk("vec_nbeats", 64'(obs_beats), 64'(vecs[v].nbeats));
         chk("vec_first_data", 64'(obs_first[31:0]), 64'(vecs[v].first_data));
         chk("vec_first_keep", 64'(obs_first[35:32]), 64'(vecs[v].first_keep));
         chk("vec_first_user", 64'(obs_first[37]), 64'd1);
         chk("vec_last_data", 64'(obs_last[31:0]), 64'(vecs[v].last_data));
         chk("vec_last_keep", 64'(obs_last[35:32]), 64'(vecs[v].last_keep));
         chk("vec_last_flag", 64'(obs_last[36]), 64'd1);
         chk("vec_id_dest", 64'(obs_last[45:38]), 64'({vecs[v].id, vecs[v].dest}));
         chk("vec_pkt_count", 64'(pkt_count), 64'(v + 1));
      end

      // Length 12, stall TREADY for 5 cycles while beat1 is presented.
      TREADY = 1'b0;
      obs_beats = 0;
      send_cmd(12, 8'h40, 4'd2, 4'd6);
      TREADY = 1'b1;
      step();
      TREADY = 1'b0;
      n = 0;
      while (!TVALID && n < 10) begin
         step();
         n++;
      end
      held = cur_beat();
      chk("stall_beat1_data", 64'(held[31:0]), 64'h47464544);
      chk("stall_beat1_last", 64'(held[36]), 64'd0);
      chk("stall_beat1_user", 64'(held[37]), 64'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_tvalid", 64'(TVALID), 64'd1);
         chk("stall_hold", 64'(cur_beat()), 64'(held));
      end
      TREADY = 1'b1;
      drain();
      chk("stall_nbeats", 64'(obs_beats), 64'd3);
      chk("stall_last_beat", 64'(obs_last[36]), 64'd1);

      // Zero-length command: accepted, nothing emitted.
      obs_beats = 0;
      send_cmd(0, 8'h55, 4'd1, 4'd1);
      for (int i = 0; i < 10; i++) begin
         chk("zero_tvalid", 64'(TVALID), 64'd0);
         chk("zero_cmd_ready", 64'(cmd_ready), 64'd1);
         step();
      end
      chk("zero_pkt_count", 64'(pkt_count), 64'(exp_pkts));
      chk("zero_nbeats", 64'(obs_beats), 64'd0);

      // Reset during beat1 of an 8-beat packet.
      TREADY = 1'b0;
      send_cmd(32, 8'h80, 4'd1, 4'd1);
      TREADY = 1'b1;
      step();
      ARESET = 1'b1;
      exp_q.delete();
      exp_pkts = '0;
      step();
      ARESET = 1'b0;
      chk("midrst_tvalid", 64'(TVALID), 64'd0);
      chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_outputs", 64'(cur_beat()), 64'd0);
      obs_beats = 0;
      send_cmd(5, 8'h33, 4'd9, 4'd10);
      drain();
      chk("midrst_first_user", 64'(obs_first[37]), 64'd1);
      chk("midrst_first_data", 64'(obs_first[31:0]), 64'h36353433);
      chk("midrst_nbeats", 64'(obs_beats), 64'd2);
      chk("midrst_pkt_count2", 64'(pkt_count), 64'd1);

      // Length 64, TREADY high: count cycles to the 16th handshake.
      obs_beats = 0;
      send_cmd(64, 8'h5A, 4'd4, 4'd4);
      n = 0;
      while (obs_beats < 16 && n < 100) begin
         step();
         n++;
      end
`ifdef AXI4S_PKT_SRC_STALL_EN
      chk("long_has_gaps", 64'(n > 16), 64'd1);
`else
      chk("long_back_to_back", 64'(n), 64'd16);
`endif
      drain();
      chk("long_nbeats", 64'(obs_beats), 64'd16);

      // Random commands with random TREADY against the model.
      rand_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
         send_cmd(len, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();
      rand_ready = 1'b0;
      chk("rand_pkt_count", 64'(pkt_count), 64'(exp_pkts));
      chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/amba_axi4_stream_pkt_src.md
Name: amba_axi4_stream_pkt_src

Overview:
- Command-driven AXI4-Stream packet source: sits directly upstream of the AXI4-Stream source-side checker harness and drives TDATA/TSTRB/TKEEP/TLAST/TID/TDEST/TUSER/TVALID into it.
- Each accepted command produces one packet with a deterministic byte pattern and length in bytes.
- Produces legal, checkable traffic for the stream VIP comparison flow.

Parameters:
- DATA_BYTES, 4, TDATA width in bytes; TSTRB/TKEEP width.
- ID_WIDTH, 4, TID width.
- DEST_WIDTH, 4, TDEST width.
- USER_WIDTH, 1, TUSER width (>=1).
- LEN_WIDTH, 16, width of the command byte length.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept, equal to (state==IDLE).
- cmd_len  in  LEN_WIDTH  packet length in bytes; 0 means drop the command.
- cmd_seed  in  8  value of byte 0 of the packet.
- cmd_id  in  ID_WIDTH  TID for the packet.
- cmd_dest  in  DEST_WIDTH  TDEST for the packet.
- TDATA  out  DATA_BYTES*8  stream data.
- TSTRB  out  DATA_BYTES  equal to TKEEP.
- TKEEP  out  DATA_BYTES  valid byte lanes.
- TLAST  out  1  last beat of the packet.
- TID  out  ID_WIDTH  latched cmd_id.
- TDEST  out  DEST_WIDTH  latched cmd_dest.
- TUSER  out  USER_WIDTH  bit0 = first beat of the packet; other bits 0.
- TVALID  out  1  stream valid.
- TREADY  in  1  stream ready.
- busy  out  1  state==SEND.
- pkt_count  out  16  number of completed packets; wraps 0xFFFF->0.

Behaviour:
- States:
  - IDLE -> SEND on cmd_valid&&cmd_ready&&cmd_len!=0.
  - A command with cmd_len==0 is accepted and stays in IDLE. No beat is produced and pkt_count is unchanged.
  - SEND -> IDLE on the handshake (TVALID&&TREADY) of the beat with TLAST=1.
- All stream outputs are registered.
- TVALID rises in the cycle after command accept, so latency from accept to first beat is 1.
- cmd_ready is low throughout SEND. There is at least one idle cycle between packets.
- Beat count = ceil(cmd_len/DATA_BYTES), computed at accept with LEN_WIDTH+1 arithmetic.
- Byte k of the packet = (cmd_seed+k) mod 256. Lane 0 is the least significant byte.
- Lanes beyond the packet end on the last beat are 0 with TKEEP=0. The last-beat TKEEP has the low (cmd_len mod DATA_BYTES) bits set, or all bits set if the remainder is 0. All other beats have TKEEP all ones.
- AXI stability rule: once TVALID=1, TDATA/TSTRB/TKEEP/TLAST/TID/TDEST/TUSER and TVALID hold until TREADY=1. The beat advances only on the handshake.
- TID and TDEST are constant for the whole packet.
- TUSER[0]=1 only on beat 0.
- Single-beat packet (cmd_len<=DATA_BYTES): TUSER[0]=1 and TLAST=1 on the same beat.
- pkt_count increments on the TLAST handshake.
- TREADY held low indefinitely: outputs are frozen and there is no timeout.
- ARESET, including mid-packet, takes effect at the next edge:
  - state=IDLE, TVALID=0, TLAST=0, busy=0, pkt_count=0, cmd_ready=1.
  - TDATA/TSTRB/TKEEP/TID/TDEST/TUSER=0.
  - The in-flight packet is abandoned, which is legal because reset is asserted.
- Any inputs are ignored while ARESET=1.

Optional Feature:
- AXI4S_PKT_SRC_STALL_EN defined:
  - A 16-bit maximal-length LFSR (x^16+x^14+x^13+x^11+1, reset value 0xACE1) steps every cycle.
  - After each non-last handshake, if LFSR bit0=1, TVALID is 0 for exactly one cycle before the next beat.
  - TVALID is never dropped without a handshake.
- Not defined: beats are back-to-back whenever TREADY=1, and no LFSR is present.

Decomposition:
- Shared package amba_axi4_stream_seda_pkg holds:
  - AXI4_STREAM_DATA_WIDTH_BYTES, AXI4_STREAM_ID_WIDTH, AXI4_STREAM_DEST_WIDTH, AXI4_STREAM_USER_WIDTH, used as parameter defaults when integrated.
  - The state enum typedef (IDLE, SEND).
  - The LFSR seed constant.
- One sub-module: amba_axi4_stream_pkt_src_lfsr (16-bit Fibonacci LFSR), instantiated only under AXI4S_PKT_SRC_STALL_EN.

Test Plan:
- Length 6, seed 0x10, id 3, dest 5, TREADY=1 ->
  - beat0: TDATA=0x13121110, TKEEP=0xF, TUSER=1, TLAST=0.
  - beat1: TDATA=0x00001514, TKEEP=0x3, TLAST=1, TID=3, TDEST=5.
  - pkt_count=1.
- Length 4, seed 0xFE -> single beat TDATA=0x0100FFFE, TKEEP=0xF, TUSER=1, TLAST=1 (byte wrap checked).
- Length 12, TREADY low for 5 cycles during beat1 -> beat1 outputs bit-identical across the stall; 3 beats total; TLAST only on beat2.
- cmd_len=0 accepted -> no TVALID for 10 cycles, pkt_count unchanged, cmd_ready stays 1.
- ARESET pulsed during beat1 of an 8-beat packet -> next cycle TVALID=0, pkt_count=0, cmd_ready=1. A new command produces a fresh packet with TUSER[0]=1 on beat 0.
- With AXI4S_PKT_SRC_STALL_EN, length 64, TREADY=1 -> exactly 16 beats with data as specified; every TVALID fall is preceded by a handshake; total cycles > 16.
